clock_set_ctrl: RTL and testbench

//  Time-setting front end for the 24 h counter chain. Button-driven FSM edits HH:MM:SS in BCD,

---
 rtl/clock_set_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button-driven HH:MM:SS editor feeding the 24 h counter's enable/load inputs.
// Define HOLD_REPEAT_EN to add auto-repeat stepping while inc/dec is held.
//
// state   | meaning
// RUN     | counter running; only a mode press is acted on
// SET_HR  | editing hours (00..23)
// SET_MIN | editing minutes (00..59)
// SET_SEC | editing seconds (00..59)
// COMMIT  | single cycle: load pulse with the edited digits
module clock_set_ctrl #(
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [3:0] cur_sec_ones,
  input  logic [3:0] cur_sec_tens,
  input  logic [3:0] cur_min_ones,
  input  logic [3:0] cur_min_tens,
  input  logic [3:0] cur_hr_ones,
  input  logic [3:0] cur_hr_tens,
  output logic       enable,
  output logic       load,
  output logic [3:0] load_sec_ones,
  output logic [3:0] load_sec_tens,
  output logic [3:0] load_min_ones,
  output logic [3:0] load_min_tens,
  output logic [3:0] load_hr_ones,
  output logic [3:0] load_hr_tens,
  output logic [1:0] edit_field
);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_HR  = 3'd1,
    SET_MIN = 3'd2,
    SET_SEC = 3'd3,
    COMMIT  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic mode_q, inc_q, dec_q;
  logic mode_press, inc_press, dec_press;
  logic in_set;
  logic step_up, step_dn;

  logic [3:0] hr_t, hr_o, min_t, min_o, sec_t, sec_o;
  logic [3:0] hr_t_nxt, hr_o_nxt, min_t_nxt, min_o_nxt, sec_t_nxt, sec_o_nxt;

  assign mode_press = btn_mode & ~mode_q;
  assign inc_press  = btn_inc & ~inc_q;
  assign dec_press  = btn_dec & ~dec_q;
  assign in_set     = (state == SET_HR) || (state == SET_MIN) || (state == SET_SEC);

  // One BCD step on a tens/ones pair wrapping at max; an invalid pair snaps to 00 or max.
  function automatic logic [7:0] bcd_step(input logic [3:0] tens, input logic [3:0] ones,
                                          input logic [3:0] max_tens, input logic [3:0] max_ones,
                                          input logic up);
    logic valid;
    logic [7:0] res;
    valid = (tens <= 4'd9) && (ones <= 4'd9) &&
            ((tens < max_tens) || ((tens == max_tens) && (ones <= max_ones)));
    if (!valid) begin
      res = up ? 8'h00 : {max_tens, max_ones};
    end else if (up) begin
      if ((tens == max_tens) && (ones == max_ones)) res = 8'h00;
      else if (ones == 4'd9)                        res = {tens + 4'd1, 4'd0};
      else                                          res = {tens, ones + 4'd1};
    end else begin
      if ((tens == 4'd0) && (ones == 4'd0)) res = {max_tens, max_ones};
      else if (ones == 4'd0)                res = {tens - 4'd1, 4'd9};
      else                                  res = {tens, ones - 4'd1};
    end
    return res;
  endfunction

`ifdef HOLD_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPT_W   = (RPT_MAX < 2) ? 1 : $clog2(RPT_MAX);

  logic [RPT_W-1:0] rpt_cnt, rpt_cnt_nxt;
  logic             rpt_act, rpt_act_nxt;
  logic             rpt_up, rpt_up_nxt;
  logic             rpt_fire;

  // Down-counter: loaded on the press edge, terminal count produces a step and reloads.
  always_comb begin
    rpt_cnt_nxt = rpt_cnt;
    rpt_act_nxt = rpt_act;
    rpt_up_nxt  = rpt_up;
    rpt_fire    = 1'b0;
    if (!in_set || mode_press || (btn_inc && btn_dec)) begin
      rpt_act_nxt = 1'b0;
    end else if (inc_press || dec_press) begin
      rpt_act_nxt = 1'b1;
      rpt_up_nxt  = inc_press;
      rpt_cnt_nxt = RPT_W'(REPEAT_DELAY - 1);
    end else if (rpt_act && (rpt_up ? btn_inc : btn_dec)) begin
      if (rpt_cnt == '0) begin
        rpt_fire    = 1'b1;
        rpt_cnt_nxt = RPT_W'(REPEAT_RATE - 1);
      end else begin
        rpt_cnt_nxt = rpt_cnt - RPT_W'(1);
      end
    end else begin
      rpt_act_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_cnt <= '0;
      rpt_act <= 1'b0;
      rpt_up  <= 1'b0;
    end else begin
      rpt_cnt <= rpt_cnt_nxt;
      rpt_act <= rpt_act_nxt;
      rpt_up  <= rpt_up_nxt;
    end
  end

  assign step_up = in_set & ~mode_press & ((inc_press & ~dec_press) | (rpt_fire & rpt_up));
  assign step_dn = in_set & ~mode_press & ((dec_press & ~inc_press) | (rpt_fire & ~rpt_up));
`else
  localparam int unsigned unused_repeat_cfg = REPEAT_DELAY ^ REPEAT_RATE;

  assign step_up = in_set & ~mode_press & inc_press & ~dec_press;
  assign step_dn = in_set & ~mode_press & dec_press & ~inc_press;
`endif

  always_comb begin
    state_nxt = state;
    hr_t_nxt  = hr_t;
    hr_o_nxt  = hr_o;
    min_t_nxt = min_t;
    min_o_nxt = min_o;
    sec_t_nxt = sec_t;
    sec_o_nxt = sec_o;
    case (state)
      RUN: begin
        if (mode_press) begin
          state_nxt = SET_HR;
          hr_t_nxt  = cur_hr_tens;
          hr_o_nxt  = cur_hr_ones;
          min_t_nxt = cur_min_tens;
          min_o_nxt = cur_min_ones;
          sec_t_nxt = cur_sec_tens;
          sec_o_nxt = cur_sec_ones;
        end
      end
      SET_HR: begin
        if (mode_press) state_nxt = SET_MIN;
        else if (step_up || step_dn)
          {hr_t_nxt, hr_o_nxt} = bcd_step(hr_t, hr_o, 4'd2, 4'd3, step_up);
      end
      SET_MIN: begin
        if (mode_press) state_nxt = SET_SEC;
        else if (step_up || step_dn)
          {min_t_nxt, min_o_nxt} = bcd_step(min_t, min_o, 4'd5, 4'd9, step_up);
      end
      SET_SEC: begin
        if (mode_press) state_nxt = COMMIT;
        else if (step_up || step_dn)
          {sec_t_nxt, sec_o_nxt} = bcd_step(sec_t, sec_o, 4'd5, 4'd9, step_up);
      end
      COMMIT:  state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      mode_q     <= 1'b0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      hr_t       <= 4'd0;
      hr_o       <= 4'd0;
      min_t      <= 4'd0;
      min_o      <= 4'd0;
      sec_t      <= 4'd0;
      sec_o      <= 4'd0;
      enable     <= 1'b1;
      load       <= 1'b0;
      edit_field <= 2'd0;
    end else begin
      state      <= state_nxt;
      mode_q     <= btn_mode;
      inc_q      <= btn_inc;
      dec_q      <= btn_dec;
      hr_t       <= hr_t_nxt;
      hr_o       <= hr_o_nxt;
      min_t      <= min_t_nxt;
      min_o      <= min_o_nxt;
      sec_t      <= sec_t_nxt;
      sec_o      <= sec_o_nxt;
      enable     <= (state_nxt == RUN);
      load       <= (state_nxt == COMMIT);
      case (state_nxt)
        SET_HR:  edit_field <= 2'd1;
        SET_MIN: edit_field <= 2'd2;
        SET_SEC: edit_field <= 2'd3;
        default: edit_field <= 2'd0;
      endcase
    end
  end

  assign load_hr_tens  = hr_t;
  assign load_hr_ones  = hr_o;
  assign load_min_tens = min_t;
  assign load_min_ones = min_o;
  assign load_sec_tens = sec_t;
  assign load_sec_ones = sec_o;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: per-cycle compare against a value-level model plus directed literal checks.
module tb_clock_set_ctrl;
  localparam int DLY  = 4;
  localparam int RATE = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [3:0] cur_sec_ones = 4'd0, cur_sec_tens = 4'd0, cur_min_ones = 4'd0;
  logic [3:0] cur_min_tens = 4'd0, cur_hr_ones = 4'd0, cur_hr_tens = 4'd0;
  logic enable, load;
  logic [3:0] load_sec_ones, load_sec_tens, load_min_ones, load_min_tens, load_hr_ones, load_hr_tens;
  logic [1:0] edit_field;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  clock_set_ctrl #(.REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_sec_ones(cur_sec_ones), .cur_sec_tens(cur_sec_tens),
    .cur_min_ones(cur_min_ones), .cur_min_tens(cur_min_tens),
    .cur_hr_ones(cur_hr_ones), .cur_hr_tens(cur_hr_tens),
    .enable(enable), .load(load),
    .load_sec_ones(load_sec_ones), .load_sec_tens(load_sec_tens),
    .load_min_ones(load_min_ones), .load_min_tens(load_min_tens),
    .load_hr_ones(load_hr_ones), .load_hr_tens(load_hr_tens),
    .edit_field(edit_field)
  );

  always #5 clk = ~clk;

  wire [23:0] dig = {load_hr_tens, load_hr_ones, load_min_tens, load_min_ones,
                     load_sec_tens, load_sec_ones};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Model: phase 0=running, 1..3=editing hr/min/sec, 4=commit; digits as plain integers.
  int m_phase = 0;
  int m_dig[6] = '{0, 0, 0, 0, 0, 0};
  bit m_pm = 0, m_pi = 0, m_pd = 0;
  int m_n = -1;
  bit m_up = 0;

  function automatic int model_step(input int t, input int o, input int maxv, input bit up);
    int v;
    v = t * 10 + o;
    if (t > 9 || o > 9 || v > maxv) return up ? 0 : maxv;
    return up ? (v + 1) % (maxv + 1) : (v + maxv) % (maxv + 1);
  endfunction

  always @(posedge clk) begin
    bit mp, ip, dp, do_up, do_dn;
    int f, v, maxv;
    if (reset) begin
      m_phase = 0;
      for (int i = 0; i < 6; i++) m_dig[i] = 0;
      m_pm = 0; m_pi = 0; m_pd = 0; m_n = -1;
    end else begin
      mp = btn_mode && !m_pm;
      ip = btn_inc && !m_pi;
      dp = btn_dec && !m_pd;
      do_up = 0; do_dn = 0;
      if (m_phase >= 1 && m_phase <= 3 && !mp) begin
        if (ip && !dp) do_up = 1;
        if (dp && !ip) do_dn = 1;
`ifdef HOLD_REPEAT_EN
        if (btn_inc && btn_dec) m_n = -1;
        else if (ip || dp) begin
          m_n = 0; m_up = ip;
        end else if (m_n >= 0 && (m_up ? btn_inc : btn_dec)) begin
          m_n++;
          if (m_n >= DLY && (m_n - DLY) % RATE == 0) begin
            if (m_up) do_up = 1; else do_dn = 1;
          end
        end else m_n = -1;
`endif
      end else m_n = -1;
      if (do_up || do_dn) begin
        f = m_phase - 1;
        maxv = (f == 0) ? 23 : 59;
        v = model_step(m_dig[2*f], m_dig[2*f+1], maxv, do_up);
        m_dig[2*f] = v / 10;
        m_dig[2*f+1] = v % 10;
      end
      if (m_phase == 4) m_phase = 0;
      else if (mp) begin
        if (m_phase == 0) begin
          m_dig[0] = cur_hr_tens;  m_dig[1] = cur_hr_ones;
          m_dig[2] = cur_min_tens; m_dig[3] = cur_min_ones;
          m_dig[4] = cur_sec_tens; m_dig[5] = cur_sec_ones;
        end
        m_phase++;
      end
      m_pm = btn_mode; m_pi = btn_inc; m_pd = btn_dec;
    end
  end

  always @(negedge clk) begin
    logic [23:0] exp_dig;
    if (chk_on) begin
      exp_dig = 0;
      for (int i = 0; i < 6; i++) exp_dig = (exp_dig << 4) | 24'(m_dig[i]);
      chk("m_enable", 32'(enable), 32'(m_phase == 0));
      chk("m_load", 32'(load), 32'(m_phase == 4));
      chk("m_field", 32'(edit_field), (m_phase >= 1 && m_phase <= 3) ? 32'(m_phase) : 32'd0);
      chk("m_digits", 32'(dig), 32'(exp_dig));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic press(input int which);
    if (which == 0) btn_mode = 1'b1;
    else if (which == 1) btn_inc = 1'b1;
    else btn_dec = 1'b1;
    cyc();
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    cyc();
  endtask

  task automatic set_cur(input logic [23:0] t);
    {cur_hr_tens, cur_hr_ones, cur_min_tens, cur_min_ones, cur_sec_tens, cur_sec_ones} = t;
  endtask

  initial begin
    // 1: reset and idle
    reset = 1'b1;
    cyc(); cyc();
    chk_on = 1'b1;
    reset = 1'b0;
    repeat (10) cyc();
    chk("rst_enable", 32'(enable), 32'd1);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_field", 32'(edit_field), 32'd0);
    chk("rst_digits", 32'(dig), 32'h0);

    // 2: capture and hour wrap
    set_cur(24'h123456);
    press(0);
    chk("cap_enable", 32'(enable), 32'd0);
    chk("cap_field", 32'(edit_field), 32'd1);
    chk("cap_digits", 32'(dig), 32'h123456);
    repeat (11) press(1);
    chk("hr_23", 32'({load_hr_tens, load_hr_ones}), 32'h23);
    press(1);
    chk("hr_wrap_00", 32'({load_hr_tens, load_hr_ones}), 32'h00);

    // 3: minutes down through 00, seconds up through 59
    press(0);
    chk("min_cap", 32'({load_min_tens, load_min_ones}), 32'h34);
    repeat (35) press(2);
    chk("min_59", 32'({load_min_tens, load_min_ones}), 32'h59);
    press(0);
    chk("sec_field", 32'(edit_field), 32'd3);
    repeat (3) press(1);
    chk("sec_59", 32'({load_sec_tens, load_sec_ones}), 32'h59);
    press(1);
    chk("sec_wrap_00", 32'({load_sec_tens, load_sec_ones}), 32'h00);

    // 4: commit pulse
    btn_mode = 1'b1;
    cyc();
    chk("commit_load", 32'(load), 32'd1);
    chk("commit_enable", 32'(enable), 32'd0);
    chk("commit_digits", 32'(dig), 32'h005900);
    btn_mode = 1'b0;
    cyc();
    chk("post_load", 32'(load), 32'd0);
    chk("post_enable", 32'(enable), 32'd1);

    // 5a: reset mid-edit
    press(0); press(0);
    repeat (3) press(2);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mid_rst_enable", 32'(enable), 32'd1);
    chk("mid_rst_field", 32'(edit_field), 32'd0);
    chk("mid_rst_load", 32'(load), 32'd0);
    repeat (3) cyc();

    // 5b: mode and inc on the same cycle
    press(0);
    btn_mode = 1'b1; btn_inc = 1'b1;
    cyc();
    btn_mode = 1'b0; btn_inc = 1'b0;
    cyc();
    chk("mode_inc_field", 32'(edit_field), 32'd2);
    chk("mode_inc_hr", 32'({load_hr_tens, load_hr_ones}), 32'h12);
    press(0); press(0);

    // 5c: out-of-range captured hour
    set_cur(24'h270000);
    press(0);
    chk("hr27_held", 32'({load_hr_tens, load_hr_ones}), 32'h27);
    press(1);
    chk("hr27_inc", 32'({load_hr_tens, load_hr_ones}), 32'h00);
    press(0); press(0); press(0);

    // 6: held inc for n=0..10
    set_cur(24'h050000);
    press(0);
    btn_inc = 1'b1;
    repeat (11) cyc();
    btn_inc = 1'b0;
    cyc();
`ifdef HOLD_REPEAT_EN
    chk("hold_hr", 32'({load_hr_tens, load_hr_ones}), 32'h10);
`else
    chk("hold_hr", 32'({load_hr_tens, load_hr_ones}), 32'h06);
`endif
    press(0); press(0); press(0);
    repeat (3) cyc();

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
